// File: rtl/ps2_key_controller.sv
// ps2_key_controller
//
// Sits between the PS/2 byte receiver and the paddle logic of the ping-pong
// game. Parses Set-2 make, break (F0) and extended (E0) sequences. Tracks the
// held state of four game keys, two per player. Drives level paddle
// commands, where the most recently pressed direction wins if both of a
// player's keys are held.
//
// Ports:
//   clock_i       system clock (50 MHz)
//   reset_i       asynchronous, active-high reset
//   rx_data_i     received byte, valid only while rx_valid_i is high
//   rx_valid_i    one-cycle strobe per received byte (>= 2 cycles apart)
//   p1_up_o       player 1 paddle up command (level)
//   p1_down_o     player 1 paddle down command (level)
//   p2_up_o       player 2 paddle up command (level)
//   p2_down_o     player 2 paddle down command (level)
//   last_code_o   final byte of the most recently completed sequence
//   code_valid_o  one-cycle pulse when a sequence completes
//   seq_err_o     one-cycle pulse on timeout or protocol error

module ps2_key_controller #(
    parameter logic [7:0] P1_UP_CODE = 8'h1D,
    parameter logic [7:0] P1_DN_CODE = 8'h1B,
    parameter logic [7:0] P2_UP_CODE = 8'h75,
    parameter logic [7:0] P2_DN_CODE = 8'h72,
    parameter int         TIMEOUT    = 50000
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       p1_up_o,
    output logic       p1_down_o,
    output logic       p2_up_o,
    output logic       p2_down_o,
    output logic [7:0] last_code_o,
    output logic       code_valid_o,
    output logic       seq_err_o
);

    localparam logic [7:0] EXT_BYTE  = 8'hE0;
    localparam logic [7:0] BRK_BYTE  = 8'hF0;
    localparam logic [7:0] BAT_PASS  = 8'hAA;
    localparam logic [7:0] BAT_FAIL  = 8'hFC;

    localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // The pulse must be visible TIMEOUT cycles after the prefix strobe, so
    // the decision is taken while the counter sits one below TIMEOUT-1.
    localparam logic [CW-1:0] FIRE = CW'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // held bit order: [0] p1 up, [1] p1 down, [2] p2 up, [3] p2 down
    logic [3:0]    held_q, held_d;
    // last_dir per player: 1 = up was the most recent make
    logic [1:0]    dir_q, dir_d;
    logic [7:0]    last_code_q, last_code_d;
    logic          code_valid_q, code_valid_d;
    logic          seq_err_q, seq_err_d;

    logic          is_make;
    logic          is_break;
    logic          is_ext;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            held_q       <= '0;
            dir_q        <= '0;
            last_code_q  <= 8'h00;
            code_valid_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            held_q       <= held_d;
            dir_q        <= dir_d;
            last_code_q  <= last_code_d;
            code_valid_q <= code_valid_d;
            seq_err_q    <= seq_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        held_d       = held_q;
        dir_d        = dir_q;
        last_code_d  = last_code_q;
        code_valid_d = 1'b0;
        seq_err_d    = 1'b0;
        is_make      = 1'b0;
        is_break     = 1'b0;
        is_ext       = 1'b0;

        if (rx_valid_i) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (rx_data_i == EXT_BYTE) begin
                        state_d = EXT;
                    end else if (rx_data_i == BRK_BYTE) begin
                        state_d = BRK;
                    end else if (rx_data_i == BAT_PASS || rx_data_i == BAT_FAIL) begin
                        // Keyboard self-test result: the keyboard has restarted,
                        // so nothing can still be held.
                        held_d       = '0;
                        code_valid_d = 1'b1;
                        last_code_d  = rx_data_i;
                        seq_err_d    = (rx_data_i == BAT_FAIL);
                    end else begin
                        is_make = 1'b1;
                    end
                end
                EXT: begin
                    // A repeated E0 is tolerated and simply restarts the wait.
                    if (rx_data_i == BRK_BYTE) begin
                        state_d = EXT_BRK;
                    end else if (rx_data_i != EXT_BYTE) begin
                        is_make = 1'b1;
                        is_ext  = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    state_d = IDLE;
                    if (rx_data_i == EXT_BYTE || rx_data_i == BRK_BYTE) begin
                        seq_err_d = 1'b1;
                    end else begin
                        is_break = 1'b1;
                        is_ext   = (state_q == EXT_BRK);
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == FIRE) begin
                seq_err_d = 1'b1;
                state_d   = IDLE;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end

        // Extended codes only ever match player 2 keys, plain codes player 1.
        if (is_make || is_break) begin
            code_valid_d = 1'b1;
            last_code_d  = rx_data_i;
            if (!is_ext) begin
                if (rx_data_i == P1_UP_CODE) begin
                    held_d[0] = is_make;
                    if (is_make) dir_d[0] = 1'b1;
                end else if (rx_data_i == P1_DN_CODE) begin
                    held_d[1] = is_make;
                    if (is_make) dir_d[0] = 1'b0;
                end
            end else begin
                if (rx_data_i == P2_UP_CODE) begin
                    held_d[2] = is_make;
                    if (is_make) dir_d[1] = 1'b1;
                end else if (rx_data_i == P2_DN_CODE) begin
                    held_d[3] = is_make;
                    if (is_make) dir_d[1] = 1'b0;
                end
            end
        end
    end

    // With both keys of a player held, last_dir selects exactly one of them.
    assign p1_up_o      = held_q[0] & (~held_q[1] |  dir_q[0]);
    assign p1_down_o    = held_q[1] & (~held_q[0] | ~dir_q[0]);
    assign p2_up_o      = held_q[2] & (~held_q[3] |  dir_q[1]);
    assign p2_down_o    = held_q[3] & (~held_q[2] | ~dir_q[1]);
    assign last_code_o  = last_code_q;
    assign code_valid_o = code_valid_q;
    assign seq_err_o    = seq_err_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
// tb_ps2_key_controller
//
// Self-checking bench for ps2_key_controller. A behavioural key model runs
// alongside the DUT and every clock cycle is compared against it. A table of
// hand-derived byte/expected-output records covers the main sequences, and
// directed sequences cover timeout, protocol errors and asynchronous reset.

module tb_ps2_key_controller;

    localparam int TIMEOUT = 40;

    logic       clock;
    logic       reset;
    logic [7:0] rxData;
    logic       rxValid;
    logic       p1Up;
    logic       p1Down;
    logic       p2Up;
    logic       p2Down;
    logic [7:0] lastCode;
    logic       codeValid;
    logic       seqErr;

    int totalCount = 0;
    int badCount   = 0;
    int edgeCount  = 0;

    // Behavioural model: keys as booleans, pending prefixes as flags.
    bit         heldM[4];     // 0 p1 up, 1 p1 down, 2 p2 up, 3 p2 down
    bit         lastUpM[2];   // per player: most recent make was "up"
    logic [7:0] lastM;
    bit         cvM;
    bit         errM;
    bit         pendExt;
    bit         pendBrk;
    int         lastByteEdge;

    typedef struct {
        logic [7:0] data;
        logic [3:0] paddle;
        logic [7:0] last;
        logic       cv;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    ps2_key_controller #(
        .P1_UP_CODE(8'h1D),
        .P1_DN_CODE(8'h1B),
        .P2_UP_CODE(8'h75),
        .P2_DN_CODE(8'h72),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .rx_data_i   (rxData),
        .rx_valid_i  (rxValid),
        .p1_up_o     (p1Up),
        .p1_down_o   (p1Down),
        .p2_up_o     (p2Up),
        .p2_down_o   (p2Down),
        .last_code_o (lastCode),
        .code_valid_o(codeValid),
        .seq_err_o   (seqErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [13:0] actualOut();
        return {p1Up, p1Down, p2Up, p2Down, lastCode, codeValid, seqErr};
    endfunction

    function automatic logic [3:0] modelPaddle();
        logic [3:0] p;
        p[3] = heldM[0] && (!heldM[1] || lastUpM[0]);
        p[2] = heldM[1] && (!heldM[0] || !lastUpM[0]);
        p[1] = heldM[2] && (!heldM[3] || lastUpM[1]);
        p[0] = heldM[3] && (!heldM[2] || !lastUpM[1]);
        return p;
    endfunction

    function automatic logic [13:0] modelOut();
        return {modelPaddle(), lastM, cvM, errM};
    endfunction

    task automatic compareValue(input string name, input logic [13:0] got, input logic [13:0] want);
        totalCount++;
        if (got !== want) begin
            badCount++;
            $display("[TB] FAIL %s at edge %0d: got %h want %h", name, edgeCount, got, want);
        end
    endtask

    task automatic checkOutput(input string name);
        compareValue(name, actualOut(), modelOut());
    endtask

    task automatic modelReset();
        for (int k = 0; k < 4; k++) heldM[k] = 0;
        lastUpM[0] = 0;
        lastUpM[1] = 0;
        lastM   = 8'h00;
        cvM     = 0;
        errM    = 0;
        pendExt = 0;
        pendBrk = 0;
    endtask

    task automatic modelKey(input logic [7:0] b, input bit make, input bit ext);
        int idx;
        cvM   = 1;
        lastM = b;
        idx   = -1;
        if (!ext && b == 8'h1D) idx = 0;
        if (!ext && b == 8'h1B) idx = 1;
        if (ext && b == 8'h75)  idx = 2;
        if (ext && b == 8'h72)  idx = 3;
        if (idx >= 0) begin
            heldM[idx] = make;
            if (make) lastUpM[idx / 2] = (idx % 2 == 0);
        end
    endtask

    task automatic modelEdge(input bit v, input logic [7:0] b);
        cvM  = 0;
        errM = 0;
        if (v) begin
            lastByteEdge = edgeCount;
            if (!pendExt && !pendBrk) begin
                if (b == 8'hE0) pendExt = 1;
                else if (b == 8'hF0) pendBrk = 1;
                else if (b == 8'hAA || b == 8'hFC) begin
                    for (int k = 0; k < 4; k++) heldM[k] = 0;
                    cvM   = 1;
                    lastM = b;
                    errM  = (b == 8'hFC);
                end else modelKey(b, 1, 0);
            end else if (!pendBrk) begin
                if (b == 8'hF0) pendBrk = 1;
                else if (b != 8'hE0) begin
                    modelKey(b, 1, 1);
                    pendExt = 0;
                end
            end else begin
                if (b == 8'hE0 || b == 8'hF0) errM = 1;
                else modelKey(b, 0, pendExt);
                pendExt = 0;
                pendBrk = 0;
            end
        end else if ((pendExt || pendBrk) && (edgeCount - lastByteEdge == TIMEOUT - 1)) begin
            errM    = 1;
            pendExt = 0;
            pendBrk = 0;
        end
    endtask

    // Drives one clock cycle of input, then checks all outputs against the model.
    task automatic applyStimulus(input bit v, input logic [7:0] d);
        rxValid = v;
        rxData  = d;
        @(posedge clock);
        #1;
        edgeCount++;
        modelEdge(v, d);
        checkOutput("cycle");
        rxValid = 1'b0;
        rxData  = 8'h00;
    endtask

    task automatic sendByte(input logic [7:0] d);
        applyStimulus(1'b1, d);
        applyStimulus(1'b0, 8'h00);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        #2;
        modelReset();
        compareValue("async_reset", actualOut(), 14'h0);
        #1;
        reset = 1'b0;
    endtask

    task automatic addVec(input logic [7:0] d, input logic [3:0] p, input logic [7:0] l,
                          input logic cv, input logic err);
        vec_t v;
        v.data   = d;
        v.paddle = p;
        v.last   = l;
        v.cv     = cv;
        v.err    = err;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] pool[9];
        int         errAt;
        int         gap;

        pool[0] = 8'h1D; pool[1] = 8'h1B; pool[2] = 8'h75;
        pool[3] = 8'h72; pool[4] = 8'hE0; pool[5] = 8'hF0;
        pool[6] = 8'hAA; pool[7] = 8'hFC; pool[8] = 8'h33;

        // paddle = {p1_up, p1_down, p2_up, p2_down}
        addVec(8'h1D, 4'b1000, 8'h1D, 1, 0);
        addVec(8'hF0, 4'b1000, 8'h1D, 0, 0);
        addVec(8'h1D, 4'b0000, 8'h1D, 1, 0);
        addVec(8'hE0, 4'b0000, 8'h1D, 0, 0);
        addVec(8'h72, 4'b0001, 8'h72, 1, 0);
        addVec(8'hE0, 4'b0001, 8'h72, 0, 0);
        addVec(8'h75, 4'b0010, 8'h75, 1, 0);
        addVec(8'hE0, 4'b0010, 8'h75, 0, 0);
        addVec(8'hF0, 4'b0010, 8'h75, 0, 0);
        addVec(8'h75, 4'b0001, 8'h75, 1, 0);
        addVec(8'hF0, 4'b0001, 8'h75, 0, 0);
        addVec(8'hF0, 4'b0001, 8'h75, 0, 1);
        addVec(8'h1D, 4'b1001, 8'h1D, 1, 0);
        addVec(8'h1B, 4'b0101, 8'h1B, 1, 0);
        addVec(8'hAA, 4'b0000, 8'hAA, 1, 0);
        addVec(8'h1D, 4'b1000, 8'h1D, 1, 0);
        addVec(8'hE0, 4'b1000, 8'h1D, 0, 0);
        addVec(8'h75, 4'b1010, 8'h75, 1, 0);
        addVec(8'hFC, 4'b0000, 8'hFC, 1, 1);
        addVec(8'hE0, 4'b0000, 8'hFC, 0, 0);
        addVec(8'hE0, 4'b0000, 8'hFC, 0, 0);
        addVec(8'h1B, 4'b0000, 8'h1B, 1, 0);
        addVec(8'h1B, 4'b0100, 8'h1B, 1, 0);
        addVec(8'h33, 4'b0100, 8'h33, 1, 0);
        addVec(8'hF0, 4'b0100, 8'h33, 0, 0);
        addVec(8'hE0, 4'b0100, 8'h33, 0, 1);
        addVec(8'hE0, 4'b0100, 8'h33, 0, 0);
        addVec(8'hF0, 4'b0100, 8'h33, 0, 0);
        addVec(8'h1D, 4'b0100, 8'h1D, 1, 0);

        rxValid = 1'b0;
        rxData  = 8'h00;
        reset   = 1'b1;
        modelReset();
        lastByteEdge = 0;
        repeat (2) @(posedge clock);
        #1;
        compareValue("reset_state", actualOut(), 14'h0);
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00);

        $display("[TB] table vectors");
        foreach (vecs[i]) begin
            applyStimulus(1'b1, vecs[i].data);
            compareValue($sformatf("vec%0d", i), actualOut(),
                         {vecs[i].paddle, vecs[i].last, vecs[i].cv, vecs[i].err});
            applyStimulus(1'b0, 8'h00);
        end

        $display("[TB] prefix timeout");
        @(negedge clock);
        resetDut();
        applyStimulus(1'b1, 8'hF0);
        errAt = -1;
        for (int k = 1; k <= TIMEOUT + 4; k++) begin
            applyStimulus(1'b0, 8'h00);
            if (seqErr === 1'b1 && errAt < 0) errAt = k;
        end
        compareValue("timeout_cycle", 14'(errAt + 1), 14'(TIMEOUT));
        sendByte(8'h1B);
        compareValue("after_timeout_make", {13'h0, p1Down}, 14'h1);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, pool[$urandom_range(0, 8)]);
            gap = ($urandom_range(0, 19) == 0) ? TIMEOUT + 1 : int'($urandom_range(1, 3));
            for (int g = 0; g < gap; g++) applyStimulus(1'b0, 8'h00);
        end

        $display("[TB] reset mid-sequence");
        @(negedge clock);
        resetDut();
        sendByte(8'h1D);
        compareValue("pre_reset_p1_up", {13'h0, p1Up}, 14'h1);
        sendByte(8'hE0);
        sendByte(8'hF0);
        @(negedge clock);
        resetDut();
        applyStimulus(1'b1, 8'h75);
        compareValue("post_reset_75", actualOut(), {4'b0000, 8'h75, 1'b1, 1'b0});
        applyStimulus(1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/ps2_key_controller.md
Name: ps2_key_controller

Overview:
- Sits between the PS/2 byte receiver and the paddle logic of the ping-pong game.
- Consumes one-cycle byte strobes and parses Set-2 make, break (F0) and extended (E0) sequences with a state machine.
- Tracks the held state of four game keys, two per player.
- Resolves conflicting up/down presses per player with last-pressed-wins and drives level paddle commands.

Parameters:
- P1_UP_CODE, 8'h1D, non-extended scan code for player 1 up (W)
- P1_DN_CODE, 8'h1B, non-extended scan code for player 1 down (S)
- P2_UP_CODE, 8'h75, extended (E0-prefixed) scan code for player 2 up (arrow up)
- P2_DN_CODE, 8'h72, extended (E0-prefixed) scan code for player 2 down (arrow down)
- TIMEOUT, 50000, clock cycles allowed between a prefix byte and the next byte (1 ms at 50 MHz)

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe, one per received byte, at least 2 cycles apart
- p1_up  out  1  player 1 paddle up command (level)
- p1_down  out  1  player 1 paddle down command (level)
- p2_up  out  1  player 2 paddle up command (level)
- p2_down  out  1  player 2 paddle down command (level)
- last_code  out  8  final byte of the most recently completed sequence
- code_valid  out  1  one-cycle pulse when a sequence completes
- seq_err  out  1  one-cycle pulse on timeout or protocol error

Behaviour:
- Reset (async, any time, including mid-sequence):
  - FSM to IDLE.
  - All held bits and all last-pressed flags cleared.
  - All outputs 0; last_code = 8'h00; timeout counter 0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- Transitions on rx_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make, non-extended -> IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT, no error; any other byte is a make, extended -> IDLE.
  - BRK: F0 or E0 -> seq_err pulse, back to IDLE, byte discarded; any other byte is a break, non-extended -> IDLE.
  - EXT_BRK: E0 or F0 -> seq_err pulse, back to IDLE; any other byte is a break, extended -> IDLE.
- Special bytes, handled only in IDLE:
  - AA (self-test pass) and FC (self-test fail): clear all held bits, pulse code_valid with last_code = the byte.
  - FC additionally pulses seq_err.
- Key matching:
  - Non-extended make/break compares against P1 codes only.
  - Extended make/break compares against P2 codes only.
  - Unmatched codes still pulse code_valid and update last_code, but change no held state.
  - Make sets the held bit; break clears it. Repeated make (typematic) is idempotent.
- Timeout:
  - Counter runs while in EXT, BRK or EXT_BRK and reloads to 0 on every rx_valid.
  - Reaching TIMEOUT-1 without a byte: seq_err pulse, FSM -> IDLE, held state unchanged.
  - In IDLE the counter is held at 0.
- Per-player resolution:
  - A last_dir flag records the direction of that player's most recent make.
  - Only up held: up=1, down=0. Only down held: up=0, down=1.
  - Both held: the direction in last_dir wins. Neither held: both 0.
  - up and down are never 1 simultaneously.
- Latency: byte strobed at cycle N -> held state, paddle outputs, last_code, code_valid and seq_err all registered, visible at N+1.
- code_valid and seq_err last exactly one cycle. Both may assert in the same cycle only for FC.

Test Plan:
- Send 1D, wait 10 cycles, send F0 1D -> p1_up=1 one cycle after the 1D strobe; p1_up=0 one cycle after the second 1D; code_valid pulses twice, last_code=1D.
- Send E0 72, then E0 75, then E0 F0 75 -> p2_down=1; then p2_up=1 with p2_down=0 (last pressed wins); after the break, p2_down=1 again since down is still held.
- Send F0 only, then idle TIMEOUT cycles -> seq_err pulse at cycle TIMEOUT after the F0 strobe, FSM in IDLE; a following 1B sets p1_down=1.
- Send F0 F0 -> seq_err on the second byte, no held change; then send 1D -> treated as a make, p1_up=1.
- Hold 1D and 75, then send AA -> all paddle outputs 0, last_code=AA, code_valid pulse, no seq_err; repeat with FC -> seq_err and code_valid in the same cycle.
- Assert reset mid-sequence after E0 F0 with p1_up held -> all outputs 0 immediately (async); after release, sending 75 yields code_valid with last_code=75, which is an extended-less make: no P2 change.
